// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch front end and its decode consumer.
// Holds default widths, reset PC, PC increment and the fetch-to-decode bundle.
package fetch_stage_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INSTR_W_DEF  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_e;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
        logic                   valid;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Instruction buffer between fetch and decode: synchronous FIFO of {instr, pc}.
// Flush empties it in one cycle and overrides any push arriving that cycle.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 2
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         push_i,
    input  logic [INSTR_W-1:0]           push_instr_i,
    input  logic [ADDR_W-1:0]            push_pc_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH):0]       occ_o,
    output fifo_state_e                  state_o,
    output logic [INSTR_W-1:0]           head_instr_o,
    output logic [ADDR_W-1:0]            head_pc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               do_pop, do_push;

    assign do_pop  = pop_i & (occ_q != '0);
    assign do_push = push_i & ((occ_q < DEPTH_C) | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge Clk) begin
        if (do_push && !flush_i) begin
            instr_mem_q[wr_ptr_q] <= push_instr_i;
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
        end
    end

    always_comb begin
        if (occ_q == '0)          state_o = FIFO_EMPTY;
        else if (occ_q == DEPTH_C) state_o = FIFO_FULL;
        else                      state_o = FIFO_PARTIAL;
    end

    assign occ_o        = occ_q;
    assign head_instr_o = (occ_q != '0) ? instr_mem_q[rd_ptr_q] : '0;
    assign head_pc_o    = (occ_q != '0) ? pc_mem_q[rd_ptr_q]    : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, read issue to a 1-cycle instruction memory,
// in-flight tracking and redirect handling, feeding decode through fetch_fifo.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INSTR_W    = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    output logic               IMemRe,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic [INSTR_W-1:0] IMemRdata,
    input  logic               BranchTaken,
    input  logic [ADDR_W-1:0]  BranchTarget,
    input  logic               DecodeStall,
    output logic               InstrValid,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [ADDR_W-1:0]  PcOut
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [OCC_W-1:0]  occ;
    fifo_state_e       fifo_state;
    logic              pop, issue, push;
    logic [OCC_W:0]    committed;

    assign InstrValid = (fifo_state != FIFO_EMPTY);
    assign pop        = InstrValid & ~DecodeStall;

    // Slots already spoken for once this cycle's pop leaves; never underflows
    // because a pop implies occ >= 1.
    assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
    assign issue     = Rst & ~BranchTaken & (committed < DEPTH_C);
    assign push      = inflight_q & ~BranchTaken;

    assign IMemRe   = issue;
    assign IMemAddr = pc_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (BranchTaken) begin
            pc_d = BranchTarget;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(PC_STEP);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge Clk) begin
        inflight_pc_q <= inflight_pc_d;
    end

    fetch_fifo #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .Clk          (Clk),
        .Rst          (Rst),
        .push_i       (push),
        .push_instr_i (IMemRdata),
        .push_pc_i    (inflight_pc_q),
        .pop_i        (pop),
        .flush_i      (BranchTaken),
        .occ_o        (occ),
        .state_o      (fifo_state),
        .head_instr_o (InstrOut),
        .head_pc_o    (PcOut)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency/stall/redirect/reset checks plus a
// randomized phase, with a scoreboard of the expected delivered PC stream.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        DecodeStall = 1'b0;
    logic        IMemRe;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdata;
    logic        InstrValid;
    logic [31:0] InstrOut;
    logic [31:0] PcOut;

    logic        w_re;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_branch = 1'b0;
    logic [31:0] w_target = 32'h0;
    logic        w_stall = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    fetch_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .IMemRe       (IMemRe),
        .IMemAddr     (IMemAddr),
        .IMemRdata    (IMemRdata),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .DecodeStall  (DecodeStall),
        .InstrValid   (InstrValid),
        .InstrOut     (InstrOut),
        .PcOut        (PcOut)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .Clk          (Clk),
        .Rst          (Rst),
        .IMemRe       (w_re),
        .IMemAddr     (w_addr),
        .IMemRdata    (w_rdata),
        .BranchTaken  (w_branch),
        .BranchTarget (w_target),
        .DecodeStall  (w_stall),
        .InstrValid   (w_valid),
        .InstrOut     (w_instr),
        .PcOut        (w_pc)
    );

    // Instruction memories: content is address ^ KEY, garbage when not read.
    always @(posedge Clk) IMemRdata <= IMemRe ? (IMemAddr ^ KEY) : $urandom;
    always @(posedge Clk) w_rdata   <= w_re   ? (w_addr ^ KEY)   : $urandom;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%08h required=%08h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: decode sees consecutive PCs from the reset PC, restarting at
    // the target of every taken branch; a pop in the branch cycle still counts.
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc = 32'h0;
    logic [31:0] exp_pc;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_pc, hold_instr;
    int          delivered = 0;

    always @(negedge Clk) begin
        if (!Rst) begin
            exp_q.delete();
            gen_pc    = 32'h0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_hold_valid", {31'b0, InstrValid}, 32'd1);
                check("stall_hold_pc", PcOut, hold_pc);
                check("stall_hold_instr", InstrOut, hold_instr);
            end
            if (BranchTaken) check("no_issue_on_branch", {31'b0, IMemRe}, 32'd0);
            if (InstrValid && !DecodeStall) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back(gen_pc);
                    gen_pc = gen_pc + 32'd4;
                end
                exp_pc = exp_q.pop_front();
                check("pop_pc", PcOut, exp_pc);
                check("pop_instr", InstrOut, exp_pc ^ KEY);
                delivered++;
            end
            hold_prev  = InstrValid && DecodeStall && !BranchTaken;
            hold_pc    = PcOut;
            hold_instr = InstrOut;
            if (BranchTaken) begin
                exp_q.delete();
                gen_pc = BranchTarget;
            end
        end
    end

    logic [31:0] wrap_tbl [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    int          w_idx = 0;

    always @(negedge Clk) begin
        if (Rst && w_valid && w_idx < 3) begin
            check("wrap_pc", w_pc, wrap_tbl[w_idx]);
            check("wrap_instr", w_instr, wrap_tbl[w_idx] ^ KEY);
            w_idx++;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) step();
        @(negedge Clk);
        check("rst_valid", {31'b0, InstrValid}, 32'd0);
        check("rst_re", {31'b0, IMemRe}, 32'd0);
        check("rst_instr", InstrOut, 32'h0);
        check("rst_pc", PcOut, 32'h0);
        check("rst_addr", IMemAddr, 32'h0);
        @(posedge Clk);
        #1 Rst = 1'b1;

        // Issue at edge 0, push at edge 1.
        @(negedge Clk);
        check("e0_re", {31'b0, IMemRe}, 32'd1);
        check("e0_addr", IMemAddr, 32'h0);
        check("e0_valid", {31'b0, InstrValid}, 32'd0);
        @(negedge Clk);
        check("e1_addr", IMemAddr, 32'h4);
        check("e1_valid", {31'b0, InstrValid}, 32'd0);
        @(negedge Clk);
        check("e2_addr", IMemAddr, 32'h8);
        check("e2_valid", {31'b0, InstrValid}, 32'd1);
        check("e2_pc", PcOut, 32'h0);
        @(posedge Clk);
        #1;
        repeat (1) step();

        DecodeStall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            check("stall_re", {31'b0, IMemRe}, 32'd0);
            step();
        end
        DecodeStall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("resume_valid", {31'b0, InstrValid}, 32'd1);
            step();
        end

        // Fill, then pop+issue once so the branch lands with a read in flight.
        DecodeStall = 1'b1;
        repeat (3) step();
        DecodeStall = 1'b0;
        step();
        DecodeStall  = 1'b1;
        BranchTaken  = 1'b1;
        BranchTarget = 32'h100;
        @(negedge Clk);
        check("br_re", {31'b0, IMemRe}, 32'd0);
        check("br_head_valid", {31'b0, InstrValid}, 32'd1);
        step();
        BranchTaken = 1'b0;
        DecodeStall = 1'b0;
        @(negedge Clk);
        check("br_addr", IMemAddr, 32'h100);
        check("br_re1", {31'b0, IMemRe}, 32'd1);
        check("br_flushed", {31'b0, InstrValid}, 32'd0);
        @(negedge Clk);
        check("br_valid1", {31'b0, InstrValid}, 32'd0);
        @(negedge Clk);
        check("br_valid2", {31'b0, InstrValid}, 32'd1);
        check("br_pc2", PcOut, 32'h100);
        step();
        repeat (3) step();

        // Branch with a pop, then a second branch that wins.
        BranchTaken  = 1'b1;
        BranchTarget = 32'h100;
        @(negedge Clk);
        check("b2_pop_valid", {31'b0, InstrValid}, 32'd1);
        step();
        BranchTarget = 32'h200;
        @(negedge Clk);
        check("b2_flushed", {31'b0, InstrValid}, 32'd0);
        check("b2_re", {31'b0, IMemRe}, 32'd0);
        step();
        BranchTaken = 1'b0;
        @(negedge Clk);
        check("b2_addr", IMemAddr, 32'h200);
        @(negedge Clk);
        check("b2_valid1", {31'b0, InstrValid}, 32'd0);
        @(negedge Clk);
        check("b2_valid2", {31'b0, InstrValid}, 32'd1);
        check("b2_pc", PcOut, 32'h200);
        step();

        delivered = 0;
        for (int i = 0; i < 400; i++) begin
            DecodeStall  = ($urandom_range(0, 99) < 35);
            BranchTaken  = ($urandom_range(0, 99) < 6);
            BranchTarget = 32'($urandom_range(0, 1023)) << 2;
            step();
        end
        BranchTaken = 1'b0;
        DecodeStall = 1'b0;
        check("liveness", {31'b0, (delivered > 80)}, 32'd1);
        repeat (3) step();

        // Asynchronous reset between edges.
        @(posedge Clk);
        #3 Rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, InstrValid}, 32'd0);
        check("arst_re", {31'b0, IMemRe}, 32'd0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
        @(negedge Clk);
        check("rs_re", {31'b0, IMemRe}, 32'd1);
        check("rs_addr", IMemAddr, 32'h0);
        check("rs_valid", {31'b0, InstrValid}, 32'd0);
        @(negedge Clk);
        check("rs_valid1", {31'b0, InstrValid}, 32'd0);
        @(negedge Clk);
        check("rs_valid2", {31'b0, InstrValid}, 32'd1);
        check("rs_pc", PcOut, 32'h0);
        step();
        repeat (10) step();

        check("wrap_count", 32'(w_idx), 32'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
